// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: integer register file with two combinational read ports,
// one synchronous write port and a per-register busy scoreboard used by decode
// to stall on pending producers.
// Optional feature: define REGFILE_BYPASS_EN for write-through forwarding of
// the writeback data and busy state onto the read ports in the write cycle.
module regfile_scoreboard #(
    parameter int XLEN     = 64,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rd_addr_1,
    input  logic [ADDR_W-1:0] rd_addr_2,
    output logic [XLEN-1:0]   rd_data_1,
    output logic [XLEN-1:0]   rd_data_2,
    output logic              rd_busy_1,
    output logic              rd_busy_2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [XLEN-1:0]   wr_data,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_rd,
    output logic [ADDR_W:0]   busy_count
);
    localparam int NREGS = 2**ADDR_W;

    logic [XLEN-1:0]            mem [NREGS];
    logic [NREGS-1:0]           busy;
    logic [ADDR_W:0]            count_q;
    logic                       wr_ok, iss_ok, set_real, clr_real;
    logic [1:0][ADDR_W-1:0]     ra;
    logic [1:0][XLEN-1:0]       rdv;
    logic [1:0]                 rbv;

    // Qualify strobes: register 0 swallows writes and issues when hardwired.
    // A real clear needs the register busy and no same-register issue this
    // edge (the new producer keeps it busy).
    always_comb begin
        wr_ok    = wr_en    && !((ZERO_REG != 0) && (wr_addr  == '0));
        iss_ok   = issue_en && !((ZERO_REG != 0) && (issue_rd == '0));
        set_real = iss_ok && !busy[issue_rd];
        clr_real = wr_ok && busy[wr_addr] && !(iss_ok && (issue_rd == wr_addr));
    end

    // Data array: cleared on reset, one write per edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) mem[i] <= '0;
        end else if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Busy bits: writeback clears, issue sets; issue is ordered last so it
    // wins on a same-register collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            if (wr_ok)  busy[wr_addr]  <= 1'b0;
            if (iss_ok) busy[issue_rd] <= 1'b1;
        end
    end

    // Busy counter tracks only real transitions, so it cannot wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            case ({set_real, clr_real})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign ra = {rd_addr_2, rd_addr_1};

    // Read ports: array contents, optional same-cycle forwarding, zero-reg mask.
    always_comb begin
        rdv = '0;
        rbv = '0;
        for (int p = 0; p < 2; p++) begin
            rdv[p] = mem[ra[p]];
            rbv[p] = busy[ra[p]];
`ifdef REGFILE_BYPASS_EN
            if (wr_ok && (wr_addr == ra[p])) begin
                rdv[p] = wr_data;
                rbv[p] = iss_ok && (issue_rd == ra[p]);
            end
`endif
            if ((ZERO_REG != 0) && (ra[p] == '0)) begin
                rdv[p] = '0;
                rbv[p] = 1'b0;
            end
        end
    end

    assign rd_data_1  = rdv[0];
    assign rd_data_2  = rdv[1];
    assign rd_busy_1  = rbv[0];
    assign rd_busy_2  = rbv[1];
    assign busy_count = count_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard (default parameters, ZERO_REG=1).
// Bypass expectations follow REGFILE_BYPASS_EN when the bench is built with it.
module tb_regfile_scoreboard;
    localparam int XLEN   = 64;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [ADDR_W-1:0] rd_addr_1, rd_addr_2, wr_addr, issue_rd;
    logic [XLEN-1:0]   rd_data_1, rd_data_2, wr_data;
    logic              rd_busy_1, rd_busy_2, wr_en, issue_en;
    logic [ADDR_W:0]   busy_count;

    int total = 0;
    int bad   = 0;

    regfile_scoreboard #(.XLEN(XLEN), .ADDR_W(ADDR_W), .ZERO_REG(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2),
        .rd_data_1(rd_data_1), .rd_data_2(rd_data_2),
        .rd_busy_1(rd_busy_1), .rd_busy_2(rd_busy_2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_en(issue_en), .issue_rd(issue_rd),
        .busy_count(busy_count)
    );

    always #5 clk = ~clk;

    // advance one rising edge, then settle 1 time unit past it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 1'b0; issue_en = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; idle();
        wr_addr = 5'd0; wr_data = '0; issue_rd = 5'd0;
        rd_addr_1 = 5'd5; rd_addr_2 = 5'd7;
        #2;
        total++; if (rd_data_1 !== 64'h0) begin bad++; $display("FAIL reset_rd1: got %h want 0", rd_data_1); end
        total++; if (rd_data_2 !== 64'h0) begin bad++; $display("FAIL reset_rd2: got %h want 0", rd_data_2); end
        total++; if ({rd_busy_1, rd_busy_2} !== 2'b00) begin bad++; $display("FAIL reset_busy: got %b want 00", {rd_busy_1, rd_busy_2}); end
        total++; if (busy_count !== 6'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", busy_count); end
        step(); step();
        rst_n = 1'b1;
        step();
        total++; if ({rd_data_1, rd_data_2, rd_busy_1, rd_busy_2, busy_count} !== '0) begin
            bad++; $display("FAIL post_reset_zero: got %h/%h b%b%b c%0d want all 0", rd_data_1, rd_data_2, rd_busy_1, rd_busy_2, busy_count);
        end
    endtask

    task automatic test_write_read();
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'hDEADBEEF_00000001;
        step();
        idle(); rd_addr_1 = 5'd5;
        #1;
        total++; if (rd_data_1 !== 64'hDEADBEEF_00000001) begin bad++; $display("FAIL wr_x5: got %h want deadbeef00000001", rd_data_1); end
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 64'hFFFF;
        step();
        idle(); rd_addr_2 = 5'd0;
        #1;
        total++; if (rd_data_2 !== 64'h0) begin bad++; $display("FAIL wr_x0: got %h want 0", rd_data_2); end
    endtask

    task automatic test_scoreboard();
        issue_en = 1'b1; issue_rd = 5'd7;
        step();
        idle(); rd_addr_1 = 5'd7;
        #1;
        total++; if (rd_busy_1 !== 1'b1) begin bad++; $display("FAIL issue_x7_busy: got %b want 1", rd_busy_1); end
        total++; if (busy_count !== 6'd1) begin bad++; $display("FAIL issue_x7_count: got %0d want 1", busy_count); end
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 64'h42;
        step();
        idle();
        #1;
        total++; if (rd_busy_1 !== 1'b0) begin bad++; $display("FAIL wb_x7_busy: got %b want 0", rd_busy_1); end
        total++; if (busy_count !== 6'd0) begin bad++; $display("FAIL wb_x7_count: got %0d want 0", busy_count); end
        total++; if (rd_data_1 !== 64'h42) begin bad++; $display("FAIL wb_x7_data: got %h want 42", rd_data_1); end
        issue_en = 1'b1; issue_rd = 5'd0;
        step();
        idle(); rd_addr_2 = 5'd0;
        #1;
        total++; if (busy_count !== 6'd0) begin bad++; $display("FAIL issue_x0_count: got %0d want 0", busy_count); end
        total++; if (rd_busy_2 !== 1'b0) begin bad++; $display("FAIL issue_x0_busy: got %b want 0", rd_busy_2); end
    endtask

    task automatic test_collision();
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 64'h99;
        issue_en = 1'b1; issue_rd = 5'd9;
        step();
        idle(); rd_addr_1 = 5'd9; rd_addr_2 = 5'd10;
        #1;
        total++; if (rd_data_1 !== 64'h99) begin bad++; $display("FAIL coll_data: got %h want 99", rd_data_1); end
        total++; if (rd_busy_1 !== 1'b1) begin bad++; $display("FAIL coll_busy: got %b want 1", rd_busy_1); end
        total++; if (busy_count !== 6'd1) begin bad++; $display("FAIL coll_count: got %0d want 1", busy_count); end
        issue_en = 1'b1; issue_rd = 5'd9;
        step();
        idle();
        #1;
        total++; if (busy_count !== 6'd1) begin bad++; $display("FAIL reissue_count: got %0d want 1", busy_count); end
        // clear x9 and set x10 on the same edge: no net change
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 64'hA9;
        issue_en = 1'b1; issue_rd = 5'd10;
        step();
        idle();
        #1;
        total++; if (busy_count !== 6'd1) begin bad++; $display("FAIL swap_count: got %0d want 1", busy_count); end
        total++; if ({rd_busy_1, rd_busy_2} !== 2'b01) begin bad++; $display("FAIL swap_busy: got %b want 01", {rd_busy_1, rd_busy_2}); end
        // write to non-busy x9: data lands, count unchanged
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 64'hB9;
        step();
        idle();
        #1;
        total++; if (busy_count !== 6'd1 || rd_data_1 !== 64'hB9) begin bad++; $display("FAIL idle_wr: got c%0d d%h want c1 db9", busy_count, rd_data_1); end
        wr_en = 1'b1; wr_addr = 5'd10; wr_data = 64'h10;
        step();
        idle();
        #1;
        total++; if (busy_count !== 6'd0) begin bad++; $display("FAIL drain_count: got %0d want 0", busy_count); end
    endtask

    task automatic test_bypass();
        logic [XLEN-1:0] exp_d;
        logic            exp_b;
        issue_en = 1'b1; issue_rd = 5'd3;
        step();
        idle();
        // x3 busy, holds 0; write 0x1234 while reading x3 in the same cycle
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'h1234; rd_addr_1 = 5'd3;
        #1;
`ifdef REGFILE_BYPASS_EN
        exp_d = 64'h1234; exp_b = 1'b0;
`else
        exp_d = 64'h0;    exp_b = 1'b1;
`endif
        total++; if (rd_data_1 !== exp_d) begin bad++; $display("FAIL byp_data: got %h want %h", rd_data_1, exp_d); end
        total++; if (rd_busy_1 !== exp_b) begin bad++; $display("FAIL byp_busy: got %b want %b", rd_busy_1, exp_b); end
        step();
        idle();
        #1;
        total++; if (rd_data_1 !== 64'h1234 || rd_busy_1 !== 1'b0) begin bad++; $display("FAIL byp_after: got %h b%b want 1234 b0", rd_data_1, rd_busy_1); end
        // write and re-issue x3 in the same cycle
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'h5678;
        issue_en = 1'b1; issue_rd = 5'd3;
        #1;
`ifdef REGFILE_BYPASS_EN
        exp_d = 64'h5678; exp_b = 1'b1;
`else
        exp_d = 64'h1234; exp_b = 1'b0;
`endif
        total++; if (rd_data_1 !== exp_d || rd_busy_1 !== exp_b) begin bad++; $display("FAIL byp_issue: got %h b%b want %h b%b", rd_data_1, rd_busy_1, exp_d, exp_b); end
        step();
        idle();
        #1;
        total++; if (rd_data_1 !== 64'h5678 || rd_busy_1 !== 1'b1 || busy_count !== 6'd1) begin
            bad++; $display("FAIL byp_issue_after: got %h b%b c%0d want 5678 b1 c1", rd_data_1, rd_busy_1, busy_count);
        end
    endtask

    task automatic test_async_reset();
        // x3 already busy; add x1, x2, x4
        for (int r = 1; r <= 4; r++) begin
            if (r != 3) begin
                issue_en = 1'b1; issue_rd = r[ADDR_W-1:0];
                step();
                idle();
            end
        end
        rd_addr_1 = 5'd5; rd_addr_2 = 5'd1;
        #1;
        total++; if (busy_count !== 6'd4) begin bad++; $display("FAIL pre_rst_count: got %0d want 4", busy_count); end
        total++; if (rd_data_1 !== 64'hDEADBEEF_00000001 || rd_busy_2 !== 1'b1) begin bad++; $display("FAIL pre_rst_state: got %h b%b", rd_data_1, rd_busy_2); end
        wr_en = 1'b1; wr_addr = 5'd6; wr_data = 64'h66;
        issue_en = 1'b1; issue_rd = 5'd8;
        #1 rst_n = 1'b0;
        #1;
        total++; if (busy_count !== 6'd0 || rd_data_1 !== 64'h0 || rd_busy_2 !== 1'b0) begin
            bad++; $display("FAIL async_clear: got c%0d d%h b%b want c0 d0 b0", busy_count, rd_data_1, rd_busy_2);
        end
        step();
        rst_n = 1'b1;
        idle();
        rd_addr_1 = 5'd6; rd_addr_2 = 5'd8;
        #1;
        total++; if (rd_data_1 !== 64'h0 || rd_busy_2 !== 1'b0 || busy_count !== 6'd0) begin
            bad++; $display("FAIL held_reset_drop: got d%h b%b c%0d want d0 b0 c0", rd_data_1, rd_busy_2, busy_count);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_scoreboard();
        test_collision();
        test_bypass();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end
endmodule
